// File: rtl/booth_pp_if.sv
// Handshake and partial-product bus between the operand source, the Booth
// recoding stage and the reduction tree of the 8x8 signed multiplier.
interface booth_pp_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] pp0;
  logic [8:0] pp1;
  logic [8:0] pp2;
  logic [8:0] pp3;
  logic [3:0] n;
  logic [1:0] occ;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, pp0, pp1, pp2, pp3, n, occ
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, pp0, pp1, pp2, pp3, n, occ
  );
endinterface

// File: rtl/booth_pp_stage.sv
// Radix-4 Booth recoding stage: accepts a/b pairs, produces four partial
// products plus negate bits through a 2-entry registered output buffer.
module booth_pp_stage #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  booth_pp_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  // Entry layout: {pp3, pp2, pp1, pp0, n}
  localparam int ENTRY_W = 40;

  occ_state_t           state_r;
  occ_state_t           state_next_s;
  logic [ENTRY_W-1:0]   head_r;
  logic [ENTRY_W-1:0]   head_next_s;
  logic [ENTRY_W-1:0]   tail_r;
  logic [ENTRY_W-1:0]   tail_next_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 accept_s;
  logic                 pop_s;
  logic [ENTRY_W-1:0]   new_entry_s;
  logic [8:0]           b_ext_s;
  logic [9:0]           dig0_s;
  logic [9:0]           dig1_s;
  logic [9:0]           dig2_s;
  logic [9:0]           dig3_s;

  // Returns {negate, pp} for one digit; negative digits are the one's
  // complement of the positive selection, the +1 arrives via the negate bit.
  function automatic logic [9:0] booth_digit(input logic [2:0] bits,
                                             input logic [7:0] mcand);
    logic [8:0] pos1;
    logic [8:0] pos2;
    logic [9:0] res;
    pos1 = {mcand[7], mcand};
    pos2 = {mcand, 1'b0};
    case (bits)
      3'b000:  res = {1'b0, 9'h000};
      3'b001:  res = {1'b0, pos1};
      3'b010:  res = {1'b0, pos1};
      3'b011:  res = {1'b0, pos2};
      3'b100:  res = {1'b1, ~pos2};
      3'b101:  res = {1'b1, ~pos1};
      3'b110:  res = {1'b1, ~pos1};
      3'b111:  res = {1'b0, 9'h000};
      default: res = {1'b0, 9'h000};
    endcase
    return res;
  endfunction

  // Recode the incoming multiplier; b[-1] is the appended zero.
  always_comb begin
    b_ext_s     = {bus.b, 1'b0};
    dig0_s      = booth_digit(b_ext_s[2:0], bus.a);
    dig1_s      = booth_digit(b_ext_s[4:2], bus.a);
    dig2_s      = booth_digit(b_ext_s[6:4], bus.a);
    dig3_s      = booth_digit(b_ext_s[8:6], bus.a);
    new_entry_s = {dig3_s[8:0], dig2_s[8:0], dig1_s[8:0], dig0_s[8:0],
                   dig3_s[9], dig2_s[9], dig1_s[9], dig0_s[9]};
  end

  // Occupancy next-state and buffer update; head always feeds the outputs.
  always_comb begin
    state_next_s = state_r;
    head_next_s  = head_r;
    tail_next_s  = tail_r;
    accept_s     = bus.in_valid && in_ready_r;
    pop_s        = out_valid_r && bus.out_ready;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          head_next_s  = new_entry_s;
          state_next_s = ST_ONE;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && pop_s) begin
          head_next_s  = new_entry_s;
          state_next_s = ST_ONE;
        end else if (accept_s) begin
          tail_next_s  = new_entry_s;
          state_next_s = ST_FULL;
        end else if (pop_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          head_next_s  = tail_r;
          state_next_s = ST_ONE;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        state_next_s = ST_EMPTY;
      end
    endcase
  end

  // State, buffer and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      head_r      <= {ENTRY_W{1'b0}};
      tail_r      <= {ENTRY_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      head_r      <= head_next_s;
      tail_r      <= tail_next_s;
      in_ready_r  <= (state_next_s != occ_state_t'(DEPTH));
      out_valid_r <= (state_next_s != ST_EMPTY);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.occ       = state_r;
  assign bus.pp3       = head_r[39:31];
  assign bus.pp2       = head_r[30:22];
  assign bus.pp1       = head_r[21:13];
  assign bus.pp0       = head_r[12:4];
  assign bus.n         = head_r[3:0];

endmodule
